// File: rtl/m3_speedrampctrl.sv
// Speed/direction sequencer for the 3-phase step calculator: ramps the step
// period once per electrical round and sequences start, stop and reversal.
module m3_speedrampctrl #(
  parameter logic [21:0] PERIOD_SLOW = 22'd2_000_000,
  parameter logic [21:0] PERIOD_FAST = 22'd20_000,
  parameter logic [21:0] DELTA       = 22'd10_000,
  parameter int unsigned RAMP_SHIFT  = 3,
  parameter logic [7:0]  PWR_INIT    = 8'd64
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  logic        startReqI,
  input  logic        forceStopI,
  input  logic        invRotateI,
  input  logic        speedINCi,
  input  logic        speedDECi,
  input  logic        powerINCi,
  input  logic        powerDECi,
  input  logic        nextCalc_1i,
  output logic        m3startO,
  output logic        m3invRotateO,
  output logic [31:0] dstRoundLenO,
  output logic [7:0]  powerLevelO,
  output logic [1:0]  stateO,
  output logic        busyO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e      state_q;
  logic [21:0] tgt_q, tgt_d;
  logic [21:0] cur_q;
  logic [21:0] ramp_run_d, ramp_stop_d;
  logic        dir_q;
  logic        rev_pend_q;
  logic [7:0]  pwr_q, pwr_d;
  logic        start_q;
  logic [22:0] tgt_sum;

  // One ramp step of cur toward goal, step = cur >> RAMP_SHIFT (min 1), never overshooting.
  function automatic logic [21:0] ramp_step(input logic [21:0] cur, input logic [21:0] goal);
    logic [21:0] s;
    logic [22:0] sum;
    s   = cur >> RAMP_SHIFT;
    if (s == 22'd0) s = 22'd1;
    sum = {1'b0, cur} + {1'b0, s};
    if (cur > goal)      ramp_step = ((cur - goal) > s) ? cur - s : goal;
    else if (cur < goal) ramp_step = (sum > {1'b0, goal}) ? goal : sum[21:0];
    else                 ramp_step = cur;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tgt_d   = tgt_q;
    pwr_d   = pwr_q;
    tgt_sum = {1'b0, tgt_q} + {1'b0, DELTA};
    if (speedINCi && !speedDECi) begin
      if ({1'b0, tgt_q} < ({1'b0, PERIOD_FAST} + {1'b0, DELTA})) tgt_d = PERIOD_FAST;
      else                                                        tgt_d = tgt_q - DELTA;
    end else if (speedDECi && !speedINCi) begin
      tgt_d = (tgt_sum > {1'b0, PERIOD_SLOW}) ? PERIOD_SLOW : tgt_sum[21:0];
    end
    if (powerINCi && !powerDECi && pwr_q != 8'hFF)      pwr_d = pwr_q + 8'd1;
    else if (powerDECi && !powerINCi && pwr_q != 8'h00) pwr_d = pwr_q - 8'd1;
    ramp_run_d  = ramp_step(cur_q, tgt_q);
    ramp_stop_d = ramp_step(cur_q, PERIOD_SLOW);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q    <= IDLE;
      tgt_q      <= PERIOD_SLOW;
      cur_q      <= PERIOD_SLOW;
      dir_q      <= 1'b0;
      rev_pend_q <= 1'b0;
      pwr_q      <= PWR_INIT;
      start_q    <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      pwr_q <= pwr_d;
      if (forceStopI) begin
        state_q    <= IDLE;
        start_q    <= 1'b0;
        cur_q      <= PERIOD_SLOW;
        rev_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (startReqI) begin
            state_q <= RAMP;
            start_q <= 1'b1;
            cur_q   <= PERIOD_SLOW;
            dir_q   <= invRotateI;
          end
          RAMP, RUN: begin
            if (!startReqI) begin
              state_q <= STOP;
            end else if (invRotateI != dir_q) begin
              state_q    <= STOP;
              rev_pend_q <= 1'b1;
            end else if (state_q == RAMP) begin
              if (cur_q == tgt_q) state_q <= RUN;
              else if (nextCalc_1i) cur_q <= ramp_run_d;
            end else if (tgt_q != cur_q) begin
              state_q <= RAMP;
            end
          end
          STOP: begin
            // Deceleration always completes before the pending request is honoured.
            if (cur_q == PERIOD_SLOW) begin
              rev_pend_q <= 1'b0;
              if (rev_pend_q && startReqI) begin
                dir_q   <= ~dir_q;
                state_q <= RAMP;
              end else begin
                start_q <= 1'b0;
                state_q <= IDLE;
              end
            end else if (nextCalc_1i) begin
              cur_q <= ramp_stop_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m3startO     = start_q;
  assign m3invRotateO = dir_q;
  assign dstRoundLenO = {10'd0, cur_q};
  assign powerLevelO  = pwr_q;
  assign stateO       = state_q;
  assign busyO        = (state_q != IDLE);

endmodule

// File: tb/tb_m3_speedrampctrl.sv
// Directed bench for m3_speedrampctrl using small periods so ramps are hand-computable.
module tb_m3_speedrampctrl;

  logic        clk = 1'b0;
  logic        nRst, startReq, forceStop, invRotate;
  logic        spdInc, spdDec, pwrInc, pwrDec, nextCalc;
  logic        m3start, m3inv, busy;
  logic [31:0] roundLen;
  logic [7:0]  pwr;
  logic [1:0]  state;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  m3_speedrampctrl #(
    .PERIOD_SLOW(22'd1000), .PERIOD_FAST(22'd100), .DELTA(22'd100),
    .RAMP_SHIFT(2), .PWR_INIT(8'd64)
  ) dut (
    .clkI(clk), .nRstI(nRst), .startReqI(startReq), .forceStopI(forceStop),
    .invRotateI(invRotate), .speedINCi(spdInc), .speedDECi(spdDec),
    .powerINCi(pwrInc), .powerDECi(pwrDec), .nextCalc_1i(nextCalc),
    .m3startO(m3start), .m3invRotateO(m3inv), .dstRoundLenO(roundLen),
    .powerLevelO(pwr), .stateO(state), .busyO(busy)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic next_calc(input int n = 1);
    repeat (n) begin
      nextCalc = 1'b1; tick(); nextCalc = 1'b0;
    end
  endtask

  task automatic pulse_speed(input logic inc, input logic dec, input int n);
    repeat (n) begin
      spdInc = inc; spdDec = dec; tick(); spdInc = 1'b0; spdDec = 1'b0;
    end
  endtask

  task automatic pulse_power(input logic inc, input logic dec, input int n);
    repeat (n) begin
      pwrInc = inc; pwrDec = dec; tick(); pwrInc = 1'b0; pwrDec = 1'b0;
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0; startReq = 1'b0; forceStop = 1'b0; invRotate = 1'b0;
    spdInc = 1'b0; spdDec = 1'b0; pwrInc = 1'b0; pwrDec = 1'b0; nextCalc = 1'b0;
    tick(2);
    checks++; if (m3start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", m3start); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (roundLen !== 32'd1000) begin failures++; $display("FAIL reset_len got=%0d exp=1000", roundLen); end
    checks++; if (pwr !== 8'd64) begin failures++; $display("FAIL reset_pwr got=%0d exp=64", pwr); end
    checks++; if (m3inv !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", m3inv); end
    nRst = 1'b1; tick();
  endtask

  task automatic test_start;
    startReq = 1'b1; tick();
    checks++; if (m3start !== 1'b1) begin failures++; $display("FAIL start_en got=%0b exp=1", m3start); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_ramp got=%0d exp=1", state); end
    checks++; if (roundLen !== 32'd1000) begin failures++; $display("FAIL start_len got=%0d exp=1000", roundLen); end
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL start_run got=%0d exp=2", state); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", busy); end
  endtask

  task automatic test_speed_up;
    pulse_speed(1'b1, 1'b0, 3);
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL spd_ramp got=%0d exp=1", state); end
    checks++; if (roundLen !== 32'd1000) begin failures++; $display("FAIL spd_len0 got=%0d exp=1000", roundLen); end
    next_calc();
    checks++; if (roundLen !== 32'd750) begin failures++; $display("FAIL spd_len1 got=%0d exp=750", roundLen); end
    next_calc();
    checks++; if (roundLen !== 32'd700) begin failures++; $display("FAIL spd_len2 got=%0d exp=700", roundLen); end
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL spd_run got=%0d exp=2", state); end
  endtask

  task automatic test_stop;
    startReq = 1'b0; tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL stop_state got=%0d exp=3", state); end
    next_calc();
    checks++; if (roundLen !== 32'd875) begin failures++; $display("FAIL stop_len1 got=%0d exp=875", roundLen); end
    checks++; if (m3start !== 1'b1) begin failures++; $display("FAIL stop_still_en got=%0b exp=1", m3start); end
    next_calc();
    checks++; if (roundLen !== 32'd1000) begin failures++; $display("FAIL stop_len2 got=%0d exp=1000", roundLen); end
    tick();
    checks++; if (m3start !== 1'b0) begin failures++; $display("FAIL stop_en got=%0b exp=0", m3start); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL stop_idle got=%0d exp=0", state); end
  endtask

  task automatic test_reverse;
    startReq = 1'b1; tick();
    next_calc(2); tick();
    checks++; if (state !== 2'd2 || roundLen !== 32'd700) begin
      failures++; $display("FAIL rev_pre got=%0d/%0d exp=2/700", state, roundLen); end
    invRotate = 1'b1; tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL rev_stop got=%0d exp=3", state); end
    next_calc();
    checks++; if (m3inv !== 1'b0 || roundLen !== 32'd875) begin
      failures++; $display("FAIL rev_mid got=%0b/%0d exp=0/875", m3inv, roundLen); end
    next_calc();
    checks++; if (m3inv !== 1'b0 || roundLen !== 32'd1000) begin
      failures++; $display("FAIL rev_slow got=%0b/%0d exp=0/1000", m3inv, roundLen); end
    tick();
    checks++; if (m3inv !== 1'b1) begin failures++; $display("FAIL rev_dir got=%0b exp=1", m3inv); end
    checks++; if (state !== 2'd1 || m3start !== 1'b1) begin
      failures++; $display("FAIL rev_ramp got=%0d/%0b exp=1/1", state, m3start); end
    next_calc();
    checks++; if (roundLen !== 32'd750) begin failures++; $display("FAIL rev_accel got=%0d exp=750", roundLen); end
  endtask

  task automatic test_force_stop;
    forceStop = 1'b1; tick();
    checks++; if (m3start !== 1'b0) begin failures++; $display("FAIL fstop_en got=%0b exp=0", m3start); end
    checks++; if (roundLen !== 32'd1000) begin failures++; $display("FAIL fstop_len got=%0d exp=1000", roundLen); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL fstop_state got=%0d exp=0", state); end
    forceStop = 1'b0; startReq = 1'b0;
    pulse_speed(1'b0, 1'b1, 5);
    startReq = 1'b1; tick(2);
    checks++; if (state !== 2'd2 || m3inv !== 1'b1) begin
      failures++; $display("FAIL slow_clamp got=%0d/%0b exp=2/1", state, m3inv); end
    pulse_speed(1'b1, 1'b0, 20);
    tick();
    next_calc(9);
    checks++; if (roundLen !== 32'd100) begin failures++; $display("FAIL fast_clamp got=%0d exp=100", roundLen); end
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL fast_run got=%0d exp=2", state); end
  endtask

  task automatic test_both_speed;
    pulse_speed(1'b1, 1'b1, 1);
    tick();
    checks++; if (state !== 2'd2 || roundLen !== 32'd100) begin
      failures++; $display("FAIL both_spd got=%0d/%0d exp=2/100", state, roundLen); end
    pulse_speed(1'b0, 1'b1, 1);
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL dec_ramp got=%0d exp=1", state); end
    next_calc();
    checks++; if (roundLen !== 32'd125) begin failures++; $display("FAIL dec_len got=%0d exp=125", roundLen); end
  endtask

  task automatic test_power;
    pulse_power(1'b1, 1'b0, 1);
    checks++; if (pwr !== 8'd65) begin failures++; $display("FAIL pwr_inc got=%0d exp=65", pwr); end
    pulse_power(1'b1, 1'b0, 199);
    checks++; if (pwr !== 8'd255) begin failures++; $display("FAIL pwr_sat_hi got=%0d exp=255", pwr); end
    pulse_power(1'b1, 1'b1, 1);
    pulse_power(1'b0, 1'b1, 1);
    checks++; if (pwr !== 8'd254) begin failures++; $display("FAIL pwr_both got=%0d exp=254", pwr); end
    pulse_power(1'b0, 1'b1, 299);
    checks++; if (pwr !== 8'd0) begin failures++; $display("FAIL pwr_sat_lo got=%0d exp=0", pwr); end
  endtask

  task automatic test_async_reset;
    checks++; if (m3start !== 1'b1) begin failures++; $display("FAIL pre_arst_en got=%0b exp=1", m3start); end
    #2 nRst = 1'b0;
    #1;
    checks++; if (m3start !== 1'b0 || state !== 2'd0 || roundLen !== 32'd1000 || pwr !== 8'd64) begin
      failures++; $display("FAIL arst got=%0b/%0d/%0d/%0d exp=0/0/1000/64", m3start, state, roundLen, pwr); end
    checks++; if (m3inv !== 1'b0) begin failures++; $display("FAIL arst_dir got=%0b exp=0", m3inv); end
    tick();
    nRst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_speed_up();
    test_stop();
    test_reverse();
    test_force_stop();
    test_both_speed();
    test_power();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
